// File: rtl/uart_pkg.sv
// Shared register map and bit positions for the UART FIFO controller.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_LEVELS  = 2'd3;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_RX_OVF       = 4;
  localparam int ST_TX_OVF       = 5;

  localparam int CTL_RX_IRQ_EN = 0;
  localparam int CTL_TX_IRQ_EN = 1;
  localparam int CTL_RX_FLUSH  = 2;
  localparam int CTL_TX_FLUSH  = 3;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with a separate occupancy counter; flush beats push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when an entry leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_fifo_controller.sv
// Memory-mapped UART controller: RX/TX FIFOs, sticky overflow flags, maskable irq.
module uart_fifo_controller
  import uart_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ren,
  input  logic              wen,
  input  logic [1:0]        address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int RX_CW = $clog2(RX_DEPTH + 1);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);

  logic              rd_en, wr_data, wr_status, wr_control, rd_data;
  logic              rx_flush, tx_flush, rx_pop, tx_pop;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic              rx_ovf_set, tx_ovf_set;
  logic [DATA_W-1:0] rx_head;
  logic [RX_CW-1:0]  rx_count;
  logic [TX_CW-1:0]  tx_count;
  logic [31:0]       status_w, rd_mux;
  logic [31:0]       data_out_q, data_out_d;
  logic              rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic              rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
  logic              irq_q, irq_d;
  logic              unused_data_in;

  assign unused_data_in = ^data_in;

  // A write in the same cycle as a read takes priority; the read is dropped.
  assign rd_en      = ren & ~wen;
  assign rd_data    = rd_en & (address == ADDR_DATA);
  assign wr_data    = wen & (address == ADDR_DATA);
  assign wr_status  = wen & (address == ADDR_STATUS);
  assign wr_control = wen & (address == ADDR_CONTROL);
  assign rx_flush   = wr_control & data_in[CTL_RX_FLUSH];
  assign tx_flush   = wr_control & data_in[CTL_TX_FLUSH];
  assign rx_pop     = rd_data & ~rx_empty;
  assign tx_pop     = tx_valid & tx_ready;
  assign rx_ovf_set = rx_valid & rx_full & ~rx_pop & ~rx_flush;
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop & ~tx_flush;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (rx_valid),
    .pop  (rd_data),
    .flush(rx_flush),
    .din  (rx_data),
    .dout (rx_head),
    .count(rx_count),
    .full (rx_full),
    .empty(rx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (wr_data),
    .pop  (tx_ready),
    .flush(tx_flush),
    .din  (data_in[DATA_W-1:0]),
    .dout (tx_data),
    .count(tx_count),
    .full (tx_full),
    .empty(tx_empty)
  );

  assign tx_valid = ~tx_empty;

  always_comb begin
    status_w                  = '0;
    status_w[ST_RX_NOT_EMPTY] = ~rx_empty;
    status_w[ST_RX_FULL]      = rx_full;
    status_w[ST_TX_EMPTY]     = tx_empty;
    status_w[ST_TX_FULL]      = tx_full;
    status_w[ST_RX_OVF]       = rx_ovf_q;
    status_w[ST_TX_OVF]       = tx_ovf_q;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = {{(32-DATA_W){1'b0}}, rx_head};
      ADDR_STATUS:  rd_mux = status_w;
      ADDR_CONTROL: rd_mux = {30'b0, tx_irq_en_q, rx_irq_en_q};
      ADDR_LEVELS:  rd_mux = {{(16-TX_CW){1'b0}}, tx_count, {(16-RX_CW){1'b0}}, rx_count};
      default:      rd_mux = '0;
    endcase
  end

  // Clear-then-set ordering makes a new overflow win over a same-cycle W1C.
  assign rx_ovf_d    = (rx_ovf_q & ~(wr_status & data_in[ST_RX_OVF])) | rx_ovf_set;
  assign tx_ovf_d    = (tx_ovf_q & ~(wr_status & data_in[ST_TX_OVF])) | tx_ovf_set;
  assign rx_irq_en_d = wr_control ? data_in[CTL_RX_IRQ_EN] : rx_irq_en_q;
  assign tx_irq_en_d = wr_control ? data_in[CTL_TX_IRQ_EN] : tx_irq_en_q;
  assign data_out_d  = rd_en ? rd_mux : data_out_q;
  assign irq_d       = (rx_irq_en_q & ~rx_empty) | (tx_irq_en_q & tx_empty) | rx_ovf_q | tx_ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q  <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_irq_en_q <= tx_irq_en_d;
      irq_q       <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Bench for uart_fifo_controller: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_uart_fifo_controller;

  localparam int DW  = 8;
  localparam int RXD = 16;
  localparam int TXD = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ren = 1'b0, wen = 1'b0;
  logic [1:0]    address = '0;
  logic [31:0]   data_in = '0;
  logic [31:0]   data_out;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  uart_fifo_controller #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk(clk), .reset(reset), .ren(ren), .wen(wen), .address(address),
    .data_in(data_in), .data_out(data_out), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: RX contents and the expected TX byte stream as queues.
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] exp_q[$];
  logic          m_rx_ovf = 0, m_tx_ovf = 0, m_rx_en = 0, m_tx_en = 0, m_irq = 0;
  logic [31:0]   m_dout = '0;

  function automatic logic [31:0] m_status();
    return {26'b0, m_tx_ovf, m_rx_ovf, logic'(exp_q.size() == TXD), logic'(exp_q.size() == 0),
            logic'(rx_q.size() == RXD), logic'(rx_q.size() != 0)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q.delete();
      exp_q.delete();
      m_rx_ovf = 0; m_tx_ovf = 0; m_rx_en = 0; m_tx_en = 0; m_irq = 0;
      m_dout = '0;
    end else begin
      logic nirq, rd, tx_popped;
      nirq = (m_rx_en && rx_q.size() > 0) || (m_tx_en && exp_q.size() == 0) || m_rx_ovf || m_tx_ovf;
      rd = ren && !wen;
      if (rd) begin
        case (address)
          2'd0: m_dout = (rx_q.size() > 0) ? {24'b0, rx_q[0]} : 32'h0;
          2'd1: m_dout = m_status();
          2'd2: m_dout = {30'b0, m_tx_en, m_rx_en};
          default: m_dout = {16'(exp_q.size()), 16'(rx_q.size())};
        endcase
      end
      tx_popped = (exp_q.size() > 0) && tx_ready;
      if (wen && address == 2'd1) begin
        if (data_in[4]) m_rx_ovf = 0;
        if (data_in[5]) m_tx_ovf = 0;
      end
      if (wen && address == 2'd2 && data_in[2]) rx_q.delete();
      else begin
        if (rd && address == 2'd0 && rx_q.size() > 0) void'(rx_q.pop_front());
        if (rx_valid) begin
          if (rx_q.size() < RXD) rx_q.push_back(rx_data);
          else m_rx_ovf = 1;
        end
      end
      if (wen && address == 2'd2 && data_in[3]) exp_q.delete();
      else begin
        if (tx_popped) void'(exp_q.pop_front());
        if (wen && address == 2'd0) begin
          if (exp_q.size() < TXD) exp_q.push_back(data_in[DW-1:0]);
          else m_tx_ovf = 1;
        end
      end
      if (wen && address == 2'd2) begin
        m_rx_en = data_in[0];
        m_tx_en = data_in[1];
      end
      m_irq = nirq;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && reset) begin
      chk("data_out", data_out, m_dout);
      chk("tx_valid", 32'(tx_valid), 32'(exp_q.size() > 0));
      chk("tx_data", 32'(tx_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic drive(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic rv, input logic [DW-1:0] rb, input logic tr);
    @(negedge clk);
    ren = r; wen = w; address = a; data_in = d; rx_valid = rv; rx_data = rb; tx_ready = tr;
    @(posedge clk);
    #1;
    ren = 0; wen = 0; rx_valid = 0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    drive(0, 1, a, d, 0, '0, tx_ready);
  endtask

  task automatic rx_strobe(input logic [DW-1:0] b);
    drive(0, 0, 2'd0, 32'h0, 1, b, tx_ready);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    drive(1, 0, a, 32'h0, 0, '0, tx_ready);
    @(negedge clk);
    chk(name, data_out, exp);
  endtask

  task automatic random_phase(input int cycles, input int tr_pct);
    for (int i = 0; i < cycles; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd2 && $urandom_range(0, 7) != 0) d[3:2] = 2'b00;
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, d,
            $urandom_range(0, 9) < 6, DW'($urandom), $urandom_range(0, 99) < tr_pct);
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1;
    check_en = 1;
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_tx_data", 32'(tx_data), 32'h0);
    chk("reset_data_out", data_out, 32'h0);
    rd_chk(2'd1, 32'h4, "status_reset");
    rd_chk(2'd3, 32'h0, "levels_reset");

    for (int i = 0; i < 3; i++) reg_wr(2'd0, 32'h41 + i);
    rd_chk(2'd3, 32'h0003_0000, "levels_tx3");
    chk("tx_head", 32'(tx_data), 32'h41);
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("tx_order", 32'(tx_data), 32'h41 + i);
      @(negedge clk);
    end
    chk("tx_drained", 32'(tx_valid), 32'h0);
    tx_ready = 0;

    for (int i = 0; i <= RXD; i++) rx_strobe(DW'(i));
    rd_chk(2'd1, 32'h17, "status_rx_full_ovf");
    rd_chk(2'd3, 32'h10, "levels_rx16");
    reg_wr(2'd1, 32'h10);
    drive(1, 0, 2'd0, 32'h0, 1, 8'h55, 0);
    @(negedge clk);
    chk("full_pushpop_head", data_out, 32'h00);
    rd_chk(2'd1, 32'h07, "status_full_no_ovf");
    rd_chk(2'd3, 32'h10, "levels_still_full");
    for (int i = 1; i < RXD; i++) rd_chk(2'd0, 32'(i), "rx_drain");
    rd_chk(2'd0, 32'h55, "rx_drain_last");
    rd_chk(2'd0, 32'h0, "rx_empty_read");
    rd_chk(2'd1, 32'h4, "status_rx_empty");

    reg_wr(2'd2, 32'h1);
    rx_strobe(8'h7E);
    @(negedge clk);
    chk("irq_not_yet", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_rises", 32'(irq), 32'h1);
    rd_chk(2'd0, 32'h7E, "irq_byte");
    @(negedge clk);
    chk("irq_falls", 32'(irq), 32'h0);

    for (int i = 0; i <= TXD; i++) reg_wr(2'd0, 32'(i));
    rd_chk(2'd1, 32'h28, "status_tx_ovf");
    reg_wr(2'd1, 32'h20);
    rd_chk(2'd1, 32'h08, "status_w1c");

    reg_wr(2'd2, 32'h8);
    for (int i = 0; i < 5; i++) reg_wr(2'd0, 32'hA0 + i);
    rd_chk(2'd3, 32'h0005_0000, "levels_tx5");
    reg_wr(2'd2, 32'h8);
    @(negedge clk);
    chk("tx_flush_valid", 32'(tx_valid), 32'h0);
    rd_chk(2'd3, 32'h0, "levels_after_flush");

    for (int i = 0; i < 3; i++) rx_strobe(8'hC0 + DW'(i));
    drive(0, 1, 2'd2, 32'h4, 1, 8'hAA, 0);
    rd_chk(2'd3, 32'h0, "rx_flush_push_levels");
    rd_chk(2'd1, 32'h4, "rx_flush_push_status");

    for (int i = 0; i < RXD; i++) rx_strobe(DW'(i));
    drive(0, 1, 2'd1, 32'h10, 1, 8'h99, 0);
    rd_chk(2'd1, 32'h17, "w1c_vs_set");
    reg_wr(2'd1, 32'h30);
    reg_wr(2'd2, 32'h4);

    random_phase(1500, 10);
    random_phase(1500, 70);

    reg_wr(2'd1, 32'h30);
    reg_wr(2'd2, 32'h1);
    tx_ready = 0;
    rx_strobe(8'h33);
    reg_wr(2'd0, 32'h44);
    drive(1, 0, 2'd1, 32'h0, 0, '0, 0);
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    chk("async_rst_data_out", data_out, 32'h0);
    chk("async_rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("async_rst_tx_data", 32'(tx_data), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1;
    rd_chk(2'd1, 32'h4, "status_after_reset");
    rd_chk(2'd3, 32'h0, "levels_after_reset");
    rd_chk(2'd2, 32'h0, "control_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
